// File: rtl/pe_weight_loader_pkg.sv
// pe_weight_loader_pkg: shared state encoding and address helper for the conv1 weight loader
package pe_weight_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] stride,
                                              input logic [31:0] idx);
        return base + stride * idx;
    endfunction

endpackage

// File: rtl/pe_weight_loader_conv1.sv
// pe_weight_loader_conv1: replays a DMA weight stream into the conv1 PE weight port as addressed writes
module pe_weight_loader_conv1
    import pe_weight_loader_pkg::*;
#(
    parameter int          pWEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
    parameter int          pADDR_STRIDE       = 8,
    parameter int          pNUM_WORDS         = 93
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  hold,
    input  logic [pWEIGHT_DATA_WIDTH-1:0]         s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic                                  load_weight,
    output logic [31:0]                           weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0]         weight_data,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(pNUM_WORDS+1)-1:0]       word_cnt
);

    localparam int CW = $clog2(pNUM_WORDS + 1);

    state_t state, state_nxt;
    logic   acc, last, launch;

    always_comb begin
        s_ready   = (state == LOAD) && !hold;
        acc       = s_ready && s_valid && !abort;
        last      = acc && (word_cnt == CW'(pNUM_WORDS - 1));
        launch    = (state == IDLE) && start && !abort;
        busy      = state != IDLE;
        state_nxt = abort ? IDLE :
                    launch ? LOAD :
                    last ? DONE :
                    (state == DONE) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // address uses the pre-increment count of the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_weight <= 1'b0;
            weight_addr <= pWEIGHT_BASE_ADDR;
            weight_data <= '0;
            done        <= 1'b0;
        end else begin
            load_weight <= acc;
            done        <= (state == DONE) && !abort;
            if (acc) begin
                weight_addr <= word_addr(pWEIGHT_BASE_ADDR, 32'(pADDR_STRIDE), 32'(word_cnt));
                weight_data <= s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      word_cnt <= '0;
        else if (launch) word_cnt <= '0;
        else if (acc)    word_cnt <= word_cnt + CW'(1);
    end

endmodule

// File: tb/tb_pe_weight_loader_conv1.sv
// tb_pe_weight_loader_conv1: randomized directed bench against a transaction-level loader model
module tb_pe_weight_loader_conv1;

    localparam int          N      = 93;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam int          STRIDE = 8;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, hold, s_valid;
    logic [63:0] s_data;
    logic        s_ready, load_weight, busy, done;
    logic [31:0] weight_addr;
    logic [63:0] weight_data;
    logic [6:0]  word_cnt;

    pe_weight_loader_conv1 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .load_weight(load_weight), .weight_addr(weight_addr), .weight_data(weight_data),
        .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int ph, cnt, dut_lw, dut_done;
    logic        exp_lw, exp_done;
    logic [31:0] exp_addr;
    logic [63:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        ph = 0; cnt = 0; exp_lw = 0; exp_done = 0; exp_addr = BASE; exp_data = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_load_weight"}, load_weight, 0);
        chk({tag, "_weight_addr"}, weight_addr, BASE);
        chk({tag, "_weight_data"}, weight_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    // one clock of stimulus; the model tracks the load as phase + word index
    task automatic cycle(input logic st, input logic ab, input logic hd, input logic vl,
                         input logic [63:0] dt);
        logic er, acc;
        @(negedge clk);
        start = st; abort = ab; hold = hd; s_valid = vl; s_data = dt;
        #1;
        er = (ph == 1) && !hd;
        chk("s_ready", s_ready, er);
        chk("busy", busy, ph != 0);
        acc = er && vl && !ab;
        @(posedge clk);
        #1;
        exp_lw = acc;
        if (acc) begin
            exp_addr = 32'(64'(BASE) + 64'(cnt) * STRIDE);
            exp_data = dt;
        end
        exp_done = (ph == 2) && !ab;
        if (ab) ph = 0;
        else if (ph == 0 && st) begin ph = 1; cnt = 0; end
        else if (acc) begin ph = (cnt == N - 1) ? 2 : 1; cnt++; end
        else if (ph == 2) ph = 0;
        dut_lw   += int'(load_weight);
        dut_done += int'(done);
        chk("load_weight", load_weight, exp_lw);
        chk("weight_addr", weight_addr, exp_addr);
        chk("weight_data", weight_data, exp_data);
        chk("done", done, exp_done);
        chk("word_cnt", word_cnt, 64'(cnt));
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; hold = 0; s_valid = 0; s_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("rst_hold");
        @(negedge clk) rst_n = 1;
        #1 chk_reset_vals("rst_rel");
        cycle(0, 0, 0, 1, 64'hdead);

        // continuous stream, data 0..92
        dut_lw = 0; dut_done = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(0, 0, 0, 1, 64'(i));
        repeat (3) cycle(0, 0, 0, 1, 64'hffff);
        chk("cont_lw_count", 64'(dut_lw), N);
        chk("cont_done_count", 64'(dut_done), 1);

        // random hold and valid gaps
        dut_lw = 0; dut_done = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000 && ph != 0; i++)
            cycle(0, 0, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        repeat (2) cycle(0, 0, 0, 1, 0);
        chk("rand_lw_count", 64'(dut_lw), N);
        chk("rand_done_count", 64'(dut_done), 1);

        // abort at word 40 with a valid beat
        dut_lw = 0; dut_done = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1, {$urandom, $urandom});
        cycle(1, 1, 0, 1, 64'h1234);
        cycle(0, 0, 0, 1, 0);
        chk("abort_lw_count", 64'(dut_lw), 40);
        chk("abort_done_count", 64'(dut_done), 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, {$urandom, $urandom});
        cycle(0, 1, 0, 0, 0);

        // start pulses during LOAD, DONE and the done cycle
        dut_lw = 0; dut_done = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            cycle((ph != 1) ? 1'b1 : 1'($urandom), 0, 1'($urandom_range(0, 3) == 0), 1, {$urandom, $urandom});
        cycle(0, 1, 0, 0, 0);
        chk("restart_done_seen", 64'(dut_done > 0), 1);

        // async reset mid-stream at word 10
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) cycle(0, 0, 0, 1, {$urandom, $urandom});
        chk("pre_rst_lw", load_weight, 1);
        #1 rst_n = 0;
        #1 chk_reset_vals("async_rst");
        model_reset();
        @(negedge clk) rst_n = 1;
        dut_lw = 0; dut_done = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(0, 0, 0, 1, {$urandom, $urandom});
        repeat (2) cycle(0, 0, 0, 0, 0);
        chk("post_rst_lw_count", 64'(dut_lw), N);
        chk("post_rst_done_count", 64'(dut_done), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pe_weight_loader_conv1.md
# pe_weight_loader_conv1

Weight-load initiator for the conv1 MAC processing element. Accepts a stream of packed weight/bias/quant words from the DMA side and replays them into the PE's weight port (`load_weight`/`weight_addr`/`weight_data`) as sequentially addressed writes. It sits between the weight DMA stream and the PE, and signals completion so the layer controller can release `en` to the PE.

## Interface

**Parameters**
- `pWEIGHT_DATA_WIDTH`, 64: width of one weight word, stream side and PE side.
- `pWEIGHT_BASE_ADDR`, 32'h4000_0000: address of the first word written to the PE.
- `pADDR_STRIDE`, 8: byte-address increment per word.
- `pNUM_WORDS`, 93: words per load (81 kernel words + 12 bias words for 3→24 ch, 3×3, int8); must be ≥1.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE.
- `abort` in 1: synchronous cancel; returns to IDLE without `done`.
- `hold` in 1: stall; while high `s_ready` is low.
- `s_data` in pWEIGHT_DATA_WIDTH: stream word.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts `s_data` this cycle.
- `load_weight` out 1: PE write strobe, registered.
- `weight_addr` out 32: PE write address, registered.
- `weight_data` out pWEIGHT_DATA_WIDTH: PE write data, registered.
- `busy` out 1: high from the cycle after `start` until `done` is driven.
- `done` out 1: one-cycle pulse; the last word has been presented to the PE.
- `word_cnt` out $clog2(pNUM_WORDS+1): words accepted in the current load.

## Operation

- States: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`. `word_cnt` clears to 0.
- In LOAD: `s_ready = !hold`. A beat is accepted when `s_valid && s_ready`.
- On an accepted beat, the next cycle drives `load_weight=1`, `weight_data=s_data`, and `weight_addr = pWEIGHT_BASE_ADDR + word_cnt*pADDR_STRIDE`, using the pre-increment count. `word_cnt` increments.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32.
- When the beat with `word_cnt == pNUM_WORDS-1` is accepted: LOAD → DONE.
- DONE: drive `done=1` for one cycle, then return to IDLE. `s_ready` is low in DONE.
- `load_weight` is low on every cycle without a preceding accepted beat. `weight_addr`/`weight_data` hold their last values.
- `start` in LOAD or DONE is ignored.
- `abort` in any state forces IDLE next cycle. Any write already registered still issues; no `done`. `abort` wins over `start` and over a simultaneous accepted beat, which is discarded (no write).
- `s_valid` is ignored in IDLE and DONE: no acceptance, no write.
- `hold` changing mid-stream only gates acceptance. Counter and address stay continuous.

## Timing

- Reset (async assert, sync deassert by the integrator) values: state IDLE, `s_ready` 0, `load_weight` 0, `weight_addr` `pWEIGHT_BASE_ADDR`, `weight_data` 0, `busy` 0, `done` 0, `word_cnt` 0.
- `start` at cycle 0: LOAD and `s_ready` at cycle 1.
- Beat accepted at cycle k: write strobe at cycle k+1. Fixed latency 1 with back-to-back throughput of 1 word/cycle.
- Last beat accepted at cycle k: last `load_weight` and DONE at cycle k+1, `done` pulse at k+2. `busy` is low at k+2; a new `start` is accepted at k+2.
- Reset mid-load: all outputs go to reset values immediately. The PE contents are undefined and the layer controller must reload.

## Structure

- `pe_weight_loader_pkg`: state enum (IDLE/LOAD/DONE) and a function computing the byte address from base, stride and index.
- Single module, no sub-modules. One FSM process, one registered output process, one counter.

## Test plan

- Reset defaults: hold `rst_n=0`, then release → all outputs at reset values, `s_ready=0`.
- Continuous stream: `start`, then 93 beats with `s_valid=1` on every cycle and data 0..92 → 93 consecutive `load_weight` pulses, addresses 0x4000_0000..0x4000_02E0 step 8, data matching, `done` exactly once two cycles after the last beat.
- Backpressure and bubbles: random `hold` and random `s_valid` gaps → same address/data sequence with no duplicates or skips, and `load_weight` count = 93.
- Abort at `word_cnt=40` with a beat also valid → no write for that beat, no `done`, IDLE next cycle. A new `start` restarts at address 0x4000_0000.
- `start` pulsed during LOAD and in the DONE cycle → ignored, single `done`. `start` in the `done` cycle (k+2) begins a new load.
- Async reset asserted mid-stream (word 10) → outputs clear in the same cycle without waiting for a clock edge. After release, `start` works normally.
